aes_dec_round_ctrl: RTL
=======================

AES_DEC_ROUND_CTRL -- requirements
Module: aes_dec_round_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ROUNDS, default 10, giving the number of AES rounds (AES-128).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the round-counter width.
REQ-003 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port reset_i, input, 1, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port in_valid_i, input, 1, meaning a ciphertext block is offered.
REQ-006 The block SHALL have port in_ready_o, output, 1, meaning the controller accepts a block.
REQ-007 The block SHALL have port en_i, input, 1, the round-advance enable; low stalls the round sequence.
REQ-008 The block SHALL have port round_o, output, CNT_W, the current round-key index.
REQ-009 The block SHALL have port load_o, output, 1, a pulse that captures the input block and applies round key NUM_ROUNDS.
REQ-010 The block SHALL have port inv_mix_en_o, output, 1, enabling InvMixColumns in the datapath.
REQ-011 The block SHALL have port round_en_o, output, 1, meaning the datapath registers the round result this cycle.
REQ-012 The block SHALL have port out_valid_o, output, 1, meaning a plaintext block is available.
REQ-013 The block SHALL have port out_ready_i, input, 1, meaning the consumer accepts the plaintext.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, ROUND, FINAL and DONE.
REQ-015 in_ready_o SHALL be 1 only in IDLE; in_valid_i && in_ready_o SHALL move IDLE to LOAD.
REQ-016 LOAD SHALL last exactly one cycle regardless of en_i, with load_o=1 and round_o=NUM_ROUNDS, then go to ROUND with round_o=NUM_ROUNDS-1.
REQ-017 In ROUND: round_en_o=en_i and inv_mix_en_o=1; with en_i=1, round_o SHALL decrement by 1; with en_i=0, everything SHALL hold.
REQ-018 In ROUND with round_o==1 and en_i=1, the FSM SHALL go to FINAL with round_o=0.
REQ-019 In FINAL: round_o=0, inv_mix_en_o=0, round_en_o=en_i; en_i=1 SHALL move to DONE.
REQ-020 In DONE, out_valid_o SHALL be 1 and held stable until out_ready_i=1, then the FSM SHALL go to IDLE.
REQ-021 in_ready_o SHALL NOT assert in the DONE exit cycle; a block is accepted at the earliest one cycle after the plaintext handshake.
REQ-022 With en_i held at 1, the latency SHALL be: accept at cycle T, load_o at T+1, round_o 9..1 at T+2..T+10, FINAL at T+11, out_valid_o at T+12.
REQ-023 round_o SHALL be 0 in IDLE and DONE.
REQ-024 round_o SHALL never wrap below 0 or exceed NUM_ROUNDS.
REQ-025 load_o, round_en_o, inv_mix_en_o and out_valid_o SHALL be mutually consistent per state and driven from registered state only, with no input-to-output combinational path except round_en_o from en_i.
REQ-026 in_valid_i SHALL be ignored outside IDLE.
REQ-027 out_ready_i SHALL be ignored outside DONE.

Reset
REQ-028 Asserting reset_i at any time, including mid-round, SHALL immediately force IDLE, round_o=0, in_ready_o=0 while reset is held, and load_o=round_en_o=inv_mix_en_o=out_valid_o=0.
REQ-029 After reset deasserts, in_ready_o SHALL be 1; an aborted block SHALL produce no out_valid_o.

Structure
REQ-030 NUM_ROUNDS, CNT_W and the FSM state enum typedef SHALL live in shared package aes_pkg.
REQ-031 The round index SHALL be held in one sub-module, counter_down_en, a CNT_W down-counter providing load value, enable, async reset and a zero flag, instantiated once.

Verification
REQ-032 The bench SHALL check: reset, then in_valid_i=1 and en_i=1 -> load_o at T+1, round_o 10,9,...,1,0 across T+1..T+11, out_valid_o at T+12, inv_mix_en_o=1 only for rounds 9..1.
REQ-033 The bench SHALL check: en_i=0 for 3 cycles while round_o=5 -> round_o stays 5, round_en_o=0; out_valid_o is delayed exactly 3 cycles (T+15).
REQ-034 The bench SHALL check: out_ready_i=0 for 4 cycles in DONE -> out_valid_o held at 1, in_ready_o=0; on out_ready_i=1, IDLE follows and in_ready_o=1 the next cycle.
REQ-035 The bench SHALL check: reset_i asserted asynchronously between clock edges while round_o=6 -> outputs go to reset values before the next edge; no out_valid_o follows.
REQ-036 The bench SHALL check: in_valid_i=1 during ROUND and DONE -> ignored, no second load_o; with in_valid_i held across DONE exit, the next load_o occurs 2 cycles after the plaintext handshake.
REQ-037 The bench SHALL check: back-to-back blocks with out_ready_i=1 -> two complete 10..0 sequences, none skipped or duplicated.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared constants and state type for the AES decryption round controller.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } dec_state_e;

endpackage

// File: rtl/aes_dec_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round controller and its neighbours.
interface aes_dec_round_ctrl_if
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = aes_pkg::CNT_W
);

  logic             in_valid_i;
  logic             in_ready_o;
  logic             en_i;
  logic [CNT_W-1:0] round_o;
  logic             load_o;
  logic             inv_mix_en_o;
  logic             round_en_o;
  logic             out_valid_o;
  logic             out_ready_i;

  // Controller side
  modport slave (
    input  in_valid_i,
    input  en_i,
    input  out_ready_i,
    output in_ready_o,
    output round_o,
    output load_o,
    output inv_mix_en_o,
    output round_en_o,
    output out_valid_o
  );

  // Producer / consumer / datapath side
  modport master (
    output in_valid_i,
    output en_i,
    output out_ready_i,
    input  in_ready_o,
    input  round_o,
    input  load_o,
    input  inv_mix_en_o,
    input  round_en_o,
    input  out_valid_o
  );

endinterface

// File: rtl/aes_dec_round_ctrl_counter_down_en.sv
// Loadable, enabled down-counter that saturates at zero; holds the round-key index.
module counter_down_en
  import aes_pkg::*;
#(
  parameter int unsigned CNT_W = aes_pkg::CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with asynchronous clear
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for an iterative AES decryption datapath: accepts a ciphertext block,
// walks the round-key index from NUM_ROUNDS down to 0, then offers the plaintext.
module aes_dec_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS,
  parameter int unsigned CNT_W      = aes_pkg::CNT_W
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  aes_dec_round_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] ROUND_FIRST = CNT_W'(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] ROUND_LAST  = CNT_W'(1);

  dec_state_e       state_q;
  dec_state_e       state_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  counter_down_en #(
    .CNT_W (CNT_W)
  ) u_round_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (ROUND_FIRST),
    .en_i       (cnt_dec),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  // State register with asynchronous return to IDLE
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and round-counter control
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid_i) begin
          state_d  = LOAD;
          cnt_load = 1'b1;
        end
      end
      LOAD: begin
        // Initial AddRoundKey uses key NUM_ROUNDS; step unconditionally
        cnt_dec = 1'b1;
        state_d = ROUND;
      end
      ROUND: begin
        if (bus.en_i) begin
          cnt_dec = 1'b1;
          // zero flag only guards against a degenerate NUM_ROUNDS setting
          if ((cnt == ROUND_LAST) || cnt_zero) begin
            state_d = FINAL;
          end
        end
      end
      FINAL: begin
        if (bus.en_i) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-state datapath controls; only round_en_o sees an input combinationally
  always_comb begin
    bus.load_o       = 1'b0;
    bus.inv_mix_en_o = 1'b0;
    bus.round_en_o   = 1'b0;
    bus.out_valid_o  = 1'b0;
    unique case (state_q)
      LOAD:    bus.load_o = 1'b1;
      ROUND: begin
        bus.inv_mix_en_o = 1'b1;
        bus.round_en_o   = bus.en_i;
      end
      FINAL:   bus.round_en_o  = bus.en_i;
      DONE:    bus.out_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Ready is masked while reset is held even though the state already reads IDLE
  assign bus.in_ready_o = (state_q == IDLE) && !reset_i;
  assign bus.round_o    = cnt;

endmodule
